// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared control-bit layout, skid state type and payload sizing for the EX/MEM pipe
package ex_mem_pkg;

    localparam int CTRL_EN_MEM  = 0;
    localparam int CTRL_EN_REG  = 1;
    localparam int CTRL_EN_JUMP = 2;
    localparam int CTRL_MEM_RD  = 3;
    localparam int CTRL_MEM_WR  = 4;
    localparam int CTRL_OP1_V   = 5;
    localparam int CTRL_OP2_V   = 6;
    localparam int CTRL_OP1_INT = 7;
    localparam int CTRL_OP2_INT = 8;
    localparam int CTRL_WR_INT  = 9;
    localparam int CTRL_WR_V    = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Payload is packed {ctrl, flags, valu, ialu}, ialu in the low bits.
    function automatic int payload_width(input int regi_size, input int elem_size,
                                         input int vect_size, input int flag_bits,
                                         input int ctrl_bits);
        return ctrl_bits + flag_bits + elem_size * vect_size + regi_size;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - width-parametrised load-enable register with synchronous clear
module pipe_payload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_skid_pipe.sv
// rtl/ex_mem_skid_pipe.sv - EX/MEM pipeline register with two-entry skid buffer, flush and bubble gating
import ex_mem_pkg::*;

module ex_mem_skid_pipe #(
    parameter int REGI_SIZE = 16,
    parameter int ELEM_SIZE = 8,
    parameter int VECT_SIZE = 8,
    parameter int FLAG_BITS = 2,
    parameter int CTRL_BITS = 11
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [REGI_SIZE-1:0]           ialu_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
    input  logic [FLAG_BITS-1:0]           alu_flags_i,
    input  logic [CTRL_BITS-1:0]           ctrl_i,
    input  logic                           flush_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [REGI_SIZE-1:0]           ialu_res_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_o,
    output logic [FLAG_BITS-1:0]           alu_flags_o,
    output logic [CTRL_BITS-1:0]           ctrl_o,
    output logic [1:0]                     occupancy_o
);

    localparam int PAY_W = payload_width(REGI_SIZE, ELEM_SIZE, VECT_SIZE, FLAG_BITS, CTRL_BITS);

    skid_state_t      state_d;
    skid_state_t      state_q;
    logic             push;
    logic             pop;
    logic             main_load;
    logic             skid_load;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] main_in;
    logic [PAY_W-1:0] main_pay;
    logic [PAY_W-1:0] skid_pay;
    logic [CTRL_BITS-1:0] main_ctrl;

    // Both handshake outputs come straight from the state flop, so
    // out_ready_i never reaches in_ready_o combinationally.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign in_pay      = {ctrl_i, alu_flags_i, valu_res_i, ialu_res_i};

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_in   = in_pay;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d   = ONE;
                    main_load = 1'b1;
                    main_in   = skid_pay;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash leaves the main payload untouched so the data outputs keep
        // showing the last presented beat while the pipe is empty.
        if (flush_i) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_payload_reg #(
        .WIDTH (PAY_W)
    ) u_main_reg (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (main_load),
        .d_i    (main_in),
        .q_o    (main_pay)
    );

    pipe_payload_reg #(
        .WIDTH (PAY_W)
    ) u_skid_reg (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (skid_load),
        .d_i    (in_pay),
        .q_o    (skid_pay)
    );

    assign {main_ctrl, alu_flags_o, valu_res_o, ialu_res_o} = main_pay;
    assign ctrl_o = main_ctrl & {CTRL_BITS{out_valid_o}};

    always_comb begin
        occupancy_o = 2'd0;
        case (state_q)
            EMPTY:   occupancy_o = 2'd0;
            ONE:     occupancy_o = 2'd1;
            FULL:    occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

endmodule

// File: doc/ex_mem_skid_pipe.md
Name: ex_mem_skid_pipe

Overview:
Parametrised execute-to-memory pipeline register for the scalar/vector datapath, successor to the fixed EX/MEM latch.
- Adds a valid/ready handshake with a two-entry skid buffer, so memory-stage backpressure stalls execute without dropping beats.
- Adds a synchronous flush for branch/jump squash.
- Forwards ALU flags.
- Gates control bits to a bubble whenever no valid beat is presented.

Parameters:
REGI_SIZE, 16, scalar ALU result width
ELEM_SIZE, 8, vector element width
VECT_SIZE, 8, vector lane count; vector result width = ELEM_SIZE*VECT_SIZE
FLAG_BITS, 2, ALU flag width
CTRL_BITS, 11, control bundle width (layout fixed in package)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
in_valid_i  in  1  execute presents a beat
in_ready_o  out  1  block can accept a beat
ialu_res_i  in  REGI_SIZE  scalar result
valu_res_i  in  ELEM_SIZE*VECT_SIZE  vector result
alu_flags_i  in  FLAG_BITS  ALU flags
ctrl_i  in  CTRL_BITS  control bundle
flush_i  in  1  squash all held and incoming beats
out_valid_o  out  1  beat presented to memory stage
out_ready_i  in  1  memory stage consumes beat
ialu_res_o  out  REGI_SIZE  held scalar result
valu_res_o  out  ELEM_SIZE*VECT_SIZE  held vector result
alu_flags_o  out  FLAG_BITS  held flags
ctrl_o  out  CTRL_BITS  held control; all-zero when out_valid_o=0
occupancy_o  out  2  entries held (0..2)

Behaviour:
Handshake and storage:
- One clock (clk_i); reset synchronous, active-high (rst_i).
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Storage: main entry (drives outputs) and skid entry. Each entry holds a valid bit and a payload {ctrl, flags, valu, ialu}.
- in_ready_o = (state != FULL). Registered from state; no combinational path from out_ready_i.

States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid). Transitions, flush and reset aside:
- EMPTY, push -> ONE; main <= input.
- EMPTY, no push -> EMPTY.
- ONE, push & pop -> ONE; main <= input.
- ONE, push & !pop -> FULL; skid <= input, main unchanged.
- ONE, !push & pop -> EMPTY.
- ONE, neither -> ONE, hold.
- FULL, pop -> ONE; main <= skid. Push is impossible in FULL.
- FULL, !pop -> FULL, hold.

Ordering and latency:
- Strict FIFO order; no beat is duplicated or lost.
- Latency 1 cycle: a beat pushed in cycle N is presented at N+1 if the block was EMPTY, or was ONE with a pop in N.

Flush (flush_i=1):
- Highest priority after reset.
- Next cycle state = EMPTY and any push in that cycle is discarded.
- in_ready_o remains as registered during the flush cycle and reads 1 the next cycle.
- A pop in the flush cycle still completes (the memory stage already sampled it).

Reset (rst_i=1):
- Next cycle: state EMPTY, all payload registers 0, out_valid_o=0, in_ready_o=1, occupancy_o=0, all data/flag/ctrl outputs 0.
- Overrides flush and handshakes; reset mid-FULL discards both entries.

Outputs:
- ctrl_o = main.ctrl & {CTRL_BITS{out_valid_o}}, so a bubble never asserts a write or jump enable.
- Data and flag outputs hold the last main payload when invalid.

Decomposition:
- Package ex_mem_pkg:
  - Control bit index constants: CTRL_EN_MEM=0, CTRL_EN_REG=1, CTRL_EN_JUMP=2, CTRL_MEM_RD=3, CTRL_MEM_WR=4, CTRL_OP1_V=5, CTRL_OP2_V=6, CTRL_OP1_INT=7, CTRL_OP2_INT=8, CTRL_WR_INT=9, CTRL_WR_V=10.
  - Typedef skid_state_t {EMPTY, ONE, FULL}.
  - Function to compute payload width.
- One sub-module, pipe_payload_reg: width-parametrised load-enable register with synchronous clear. Instantiated for main and skid.

Test Plan:
- Reset: rst_i=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, occupancy_o=0, all outputs 0.
- Streaming: out_ready_i=1, push ialu 0x0001..0x0004 on consecutive cycles -> each appears one cycle later in order, occupancy_o stays 1, in_ready_o stays 1.
- Backpressure: out_ready_i=0, push A (ialu 0x00AA), then B (0x00BB) -> occupancy_o=2, in_ready_o=0, output holds A.
  - Raise out_ready_i -> A, then B on successive cycles; occupancy 2->1->0.
- Flush while FULL: flush_i=1 with in_valid_i=1 (ialu 0x00CC) -> next cycle out_valid_o=0, ctrl_o=0, occupancy_o=0, in_ready_o=1; 0x00CC never appears.
- Bubble gating: push ctrl=0x7FF, valu=0x0102030405060708, flags=2'b11, then pop with no new push -> ctrl_o=0 while out_valid_o=0; valu_res_o and alu_flags_o retain the values.
- Reset mid-stream: FULL state with rst_i and out_ready_i both 1 -> next cycle EMPTY, no beat presented afterwards.
